// File: rtl/usb_ep_status_csr_pkg.sv
// Shared encodings for the USB endpoint status CSR bridge: bus op codes,
// bridge FSM states, aux-port read latency and the read-modify-write merge rule.
package usb_ep_status_csr_pkg;

    typedef enum logic [1:0] {
        OP_PLAIN = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_RC    = 2'b11
    } ep_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        ACK     = 3'd4
    } ep_state_e;

    localparam int RD_LAT_DEFAULT = 3;

    // New word value for a write op, given the old word and the bus mask/data.
    function automatic logic [15:0] merge_wdata(ep_op_e op, logic [15:0] old_word,
                                                logic [15:0] mask);
        logic [15:0] res;
        res = mask;
        case (op)
            OP_PLAIN: res = mask;
            OP_SET:   res = old_word | mask;
            OP_CLR:   res = old_word & ~mask;
            OP_RC:    res = 16'h0000;
            default:  res = mask;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/usb_ep_status_csr.sv
// Bus-to-aux-port bridge for endpoint status words: plain read/write plus
// bit-set, bit-clear and read-and-clear done as read-modify-write on the aux port.
module usb_ep_status_csr
    import usb_ep_status_csr_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc,
    input  logic        wb_we,
    input  logic [9:0]  wb_addr,
    input  logic [15:0] wb_wdata,
    output logic [15:0] wb_rdata,
    output logic        wb_ack,
    output logic [7:0]  s_addr_0,
    output logic        s_read_0,
    output logic        s_zero_0,
    output logic        s_write_0,
    output logic [15:0] s_din_0,
    input  logic [15:0] s_dout_3,
    input  logic        s_ready_0
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    // Aux handshake: a request stays asserted with frozen s_addr_0/s_din_0
    // until a cycle where s_ready_0=1; that cycle is the accept.
    ep_state_e        state;
    ep_op_e           op_q;
    logic             we_q;
    logic [15:0]      wdata_q;
    logic [15:0]      data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drop_q;

    assign s_read_0  = (state == RD_REQ);
    assign s_write_0 = (state == WR_REQ);
    assign s_zero_0  = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_PLAIN;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            data_q   <= 16'h0000;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            s_addr_0 <= 8'h00;
            s_din_0  <= 16'h0000;
            wb_rdata <= 16'h0000;
            wb_ack   <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            // A master that lets go mid-op still gets its aux access, just no ack.
            if (state != IDLE && !wb_cyc) begin
                drop_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    drop_q   <= 1'b0;
                    wb_rdata <= 16'h0000;
                    if (wb_cyc) begin
                        op_q     <= ep_op_e'(wb_addr[9:8]);
                        we_q     <= wb_we;
                        wdata_q  <= wb_wdata;
                        s_addr_0 <= wb_addr[7:0];
                        if (wb_we && ep_op_e'(wb_addr[9:8]) == OP_PLAIN) begin
                            s_din_0 <= wb_wdata;
                            state   <= WR_REQ;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (s_ready_0) begin
                        cnt_q <= '0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        data_q <= s_dout_3;
                        if (we_q && op_q != OP_PLAIN) begin
                            s_din_0 <= merge_wdata(op_q, s_dout_3, wdata_q);
                            state   <= WR_REQ;
                        end else begin
                            state    <= ACK;
                            wb_ack   <= wb_cyc && !drop_q;
                            wb_rdata <= s_dout_3;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WR_REQ: begin
                    if (s_ready_0) begin
                        state    <= ACK;
                        wb_ack   <= wb_cyc && !drop_q;
                        wb_rdata <= (op_q == OP_PLAIN) ? 16'h0000 : data_q;
                    end
                end
                ACK: begin
                    wb_rdata <= 16'h0000;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_ep_status_csr.md
USB_EP_STATUS_CSR -- requirements
Module: usb_ep_status_csr

Interface
REQ-001 The block SHALL have one clock and one reset: clk is the single clock; rst_n is asynchronous and active-low.
REQ-002 Port list, one per line: name  direction  width  meaning.
  clk  in  1  system clock
  rst_n  in  1  async reset, active-low
  wb_cyc  in  1  bus cycle request, held by master until wb_ack
  wb_we  in  1  1 = write, 0 = read
  wb_addr  in  10  [7:0] EP status word address; [9:8] op (00 plain, 01 bit-set, 10 bit-clear, 11 read-and-clear)
  wb_wdata  in  16  write data or bit mask
  wb_rdata  out  16  read data, valid with wb_ack
  wb_ack  out  1  one-cycle completion pulse
  s_addr_0  out  8  aux port address
  s_read_0  out  1  aux read request
  s_zero_0  out  1  aux zero-read request, driven constant 0
  s_write_0  out  1  aux write request
  s_din_0  out  16  aux write data
  s_dout_3  in  16  aux read data, valid 3 cycles after the read is accepted
  s_ready_0  in  1  aux request accepted this cycle (combinational, priority port idle)
REQ-003 Parameter, one per line: name, default, meaning.
  RD_LAT, 3, aux port read latency in cycles from accept to valid s_dout_3.

Function
REQ-004 An aux request SHALL count as accepted only in a cycle where it is asserted and s_ready_0=1; otherwise it SHALL be held, with identical address and data, into the next cycle.
REQ-005 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, ACK; s_read_0 = (state==RD_REQ), s_write_0 = (state==WR_REQ).
REQ-006 IDLE with wb_cyc=1 SHALL latch wb_addr, wb_we and wb_wdata, then go to WR_REQ for a plain write (op 00, we=1) and to RD_REQ for every other case.
REQ-007 RD_REQ SHALL go to RD_WAIT on acceptance; RD_WAIT SHALL count RD_LAT cycles and capture s_dout_3 into a data register in the last counted cycle.
REQ-008 After RD_WAIT, a plain read or any op with wb_we=0 SHALL go to ACK; ops 01/10/11 with wb_we=1 SHALL go to WR_REQ.
REQ-009 Write data SHALL be: op 00 = wdata; op 01 = old|wdata; op 10 = old&~wdata; op 11 = 16'h0000.
REQ-010 WR_REQ SHALL go to ACK on acceptance; ACK SHALL assert wb_ack for exactly one cycle and return to IDLE.
REQ-011 wb_rdata SHALL be the captured old value for reads and RMW ops, and 16'h0000 for plain writes.
REQ-012 Uncontended latency from the wb_cyc sample cycle 0: plain write ack in cycle 2; read ack in cycle 5; RMW write in cycle 5 and ack in cycle 6. Each stall cycle adds one cycle.
REQ-013 If wb_cyc drops before ack, the in-flight op SHALL complete on the aux port and wb_ack SHALL be suppressed.
REQ-014 An RMW SHALL NOT be atomic against the priority port; priority-port writes between the read and the write are overwritten. This is an accepted limitation.
REQ-015 A new wb_cyc SHALL NOT be sampled in the ACK cycle; the earliest next sample is IDLE in the following cycle.

Reset
REQ-016 While rst_n=0, state SHALL be IDLE and wb_ack, s_read_0, s_write_0, s_zero_0, s_addr_0, s_din_0 and wb_rdata SHALL all be 0.
REQ-017 Reset mid-operation SHALL abandon the op with no ack. The RD_WAIT counter and data register SHALL clear.

Structure
REQ-018 Op encodings (00/01/10/11), FSM state encodings and RD_LAT default SHALL live in a shared usb_ep_status package.
REQ-019 The block SHALL be a single module with no sub-modules; it connects to the aux port of usb_ep_status.

Verification
REQ-020 Plain write to addr 0x12 with 0xBEEF, s_ready_0=1 -> s_write_0 in cycle 1 with s_addr_0=0x12 and s_din_0=0xBEEF; wb_ack in cycle 2.
REQ-021 Read of addr 0x12 holding 0xBEEF -> s_read_0 in cycle 1, wb_ack in cycle 5, wb_rdata=0xBEEF.
REQ-022 Bit-set (op 01), mask 0x0101, word 0x1000 -> written 0x1101, rdata 0x1000, ack in cycle 6. Bit-clear (op 10), mask 0x1000 -> written 0x0101.
REQ-023 s_ready_0=0 for 4 cycles during RD_REQ -> s_read_0 held with stable s_addr_0, ack delayed exactly 4 cycles.
REQ-024 Read-and-clear (op 11) of 0x00A5 -> rdata 0x00A5 and the word reads back 0x0000; wb_cyc dropped mid-op -> write still issued and no wb_ack.
REQ-025 rst_n pulsed low during RD_WAIT -> all outputs 0 immediately, no ack, and the next write completes normally in 2 cycles.
